// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller for the EXE-stage 32x32 multiplier (MUL.W, MULH.W, MULH.WU).
// Drives operands, waits out the multiplier latency and holds the selected word on a valid/ready port.
module mul_issue_ctrl #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mul_sign,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    input  logic [63:0]      mul_p,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] OP_MULH_W  = 2'd1;
    localparam logic [1:0] OP_MULH_WU = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   lat_cnt;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  src1_q;
    logic [DATA_W-1:0]  src2_q;
    logic [TAG_W-1:0]   tag_q;

    logic               accept;
    logic [1:0]         op_drv;
    logic               hi_sel;
    logic [DATA_W-1:0]  sel_word;

    assign req_ready = ~flush & ((state == S_IDLE) | ((state == S_DONE) & rsp_ready));
    assign accept    = req_valid & req_ready;

    // Request feeds the multiplier directly in the accept cycle, latched copies afterwards.
    assign op_drv    = accept ? req_op   : op_q;
    assign mul_x     = accept ? req_src1 : src1_q;
    assign mul_y     = accept ? req_src2 : src2_q;
    assign mul_sign  = (op_drv == OP_MULH_W);

    assign hi_sel    = (op_q == OP_MULH_W) | (op_q == OP_MULH_WU);
    assign sel_word  = hi_sel ? mul_p[63:32] : mul_p[31:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            op_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            tag_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end
                S_CALC: begin
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        rsp_result <= sel_word;
                        rsp_tag    <= tag_q;
                        rsp_valid  <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase

            // A new op overrides the idle/response transition above (covers back-to-back).
            if (accept) begin
                op_q    <= req_op;
                src1_q  <= req_src1;
                src2_q  <= req_src2;
                tag_q   <= req_tag;
                lat_cnt <= CNT_W'(MUL_LAT);
                state   <= S_CALC;
            end
        end
    end

endmodule
